// File: rtl/pa_fpu_special_dp_q.sv
// FPU special-result datapath stage: unboxes and classifies three sources, builds IEEE special
// results for an EXP_W/MAN_W format and queues them with flags and rounding mode.
module pa_fpu_special_dp_q #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             ex1_vld,
  output logic             ex1_rdy,
  input  logic [OUT_W-1:0] ex1_srcf0,
  input  logic [OUT_W-1:0] ex1_srcf1,
  input  logic [OUT_W-1:0] ex1_srcf2,
  input  logic             ex1_src2_vld,
  input  logic [2:0]       ex1_src_sel,
  input  logic [6:0]       ex1_res_sel,
  input  logic [3:0]       ex1_sign,
  input  logic [4:0]       ex1_fflags,
  input  logic [2:0]       ex1_decode_rm,
  input  logic [2:0]       cp0_fpu_xx_rm,
  output logic [20:0]      ex1_src_cls,
  output logic             ex2_vld,
  input  logic             ex2_rdy,
  output logic [OUT_W-1:0] ex2_data,
  output logic [4:0]       ex2_fflags,
  output logic [2:0]       ex2_rm,
  output logic             ex2_wb,
  input  logic             acc_clr,
  output logic [4:0]       acc_fflags
);

  localparam int unsigned FLEN  = 1 + EXP_W + MAN_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [FLEN-1:0]  CNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

  // Per-source class bits, ordered {id,norm,zero,inf,qnan,snan,cnan}.
  function automatic logic [6:0] classify(input logic [FLEN-1:0] v);
    logic e_ones, e_zero, m_zero, m_msb, m_rest0;
    logic [6:0] c;
    e_ones  = &v[FLEN-2:MAN_W];
    e_zero  = ~|v[FLEN-2:MAN_W];
    m_zero  = ~|v[MAN_W-1:0];
    m_msb   = v[MAN_W-1];
    m_rest0 = ~|v[MAN_W-2:0];
    c[6] = e_zero & ~m_zero;
    c[5] = ~e_zero & ~e_ones;
    c[4] = e_zero & m_zero;
    c[3] = e_ones & m_zero;
    c[2] = e_ones & m_msb;
    c[1] = e_ones & ~m_msb & ~m_zero;
    c[0] = e_ones & m_msb & m_rest0 & ~v[FLEN-1];
    return c;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  logic [OUT_W-1:0] raw [3];
  logic [FLEN-1:0]  unb [3];
  logic [FLEN-1:0]  src [3];
  logic [FLEN-1:0]  sel_src;
  logic [FLEN-1:0]  res;
  logic [OUT_W-1:0] push_data;
  logic             wb;

  assign raw[0] = ex1_srcf0;
  assign raw[1] = ex1_srcf1;
  assign raw[2] = ex1_srcf2;
  assign wb     = |ex1_res_sel;

  if (OUT_W > FLEN) begin : g_box
    for (genvar gi = 0; gi < 3; gi++) begin : g_unbox
      assign unb[gi] = (&raw[gi][OUT_W-1:FLEN]) ? raw[gi][FLEN-1:0] : CNAN;
    end
    assign push_data = wb ? {{(OUT_W-FLEN){1'b1}}, res} : '0;
  end else begin : g_nobox
    for (genvar gi = 0; gi < 3; gi++) begin : g_unbox
      assign unb[gi] = raw[gi][FLEN-1:0];
    end
    assign push_data = wb ? res : '0;
  end

  assign src[0] = unb[0];
  assign src[1] = unb[1];
  assign src[2] = ex1_src2_vld ? unb[2] : '0;

  assign ex1_src_cls = {classify(src[2]), classify(src[1]), classify(src[0])};

  always_comb begin
    sel_src = src[2];
    case (ex1_src_sel)
      3'b001:  sel_src = src[0];
      3'b010:  sel_src = src[1];
      default: sel_src = src[2];
    endcase
  end

  // Lowest set bit of ex1_res_sel selects the result kind.
  always_comb begin
    res = '0;
    if (ex1_res_sel[0])      res = {ex1_sign[0], sel_src[FLEN-2:0]};
    else if (ex1_res_sel[1]) res = {ex1_sign[1], {(FLEN-1){1'b0}}};
    else if (ex1_res_sel[2]) res = {ex1_sign[2], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (ex1_res_sel[3]) res = {ex1_sign[3], {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    else if (ex1_res_sel[4]) res = CNAN;
    else if (ex1_res_sel[5]) res = {sel_src[FLEN-1], {EXP_W{1'b1}}, 1'b1, sel_src[MAN_W-2:0]};
    else if (ex1_res_sel[6]) res = sel_src;
  end

  logic [OUT_W-1:0] data_q [DEPTH];
  logic [4:0]       ff_q   [DEPTH];
  logic [2:0]       rm_q   [DEPTH];
  logic             wb_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       acc_q, acc_d;
  logic             push, pop;

  assign ex1_rdy = ~cpurst & (count_q < DEPTH_C);
  assign push    = ex1_vld & ex1_rdy;
  assign ex2_vld = (count_q != '0);
  assign pop     = ex2_vld & ex2_rdy;

  assign ex2_data   = ex2_vld ? data_q[rd_ptr_q] : '0;
  assign ex2_fflags = ex2_vld ? ff_q[rd_ptr_q]   : '0;
  assign ex2_rm     = ex2_vld ? rm_q[rd_ptr_q]   : '0;
  assign ex2_wb     = ex2_vld ? wb_q[rd_ptr_q]   : 1'b0;
  assign acc_fflags = acc_q;

  always_comb begin
    wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // A clear in the same cycle as a pop still keeps the popped flags.
    acc_d = (acc_clr ? 5'b0 : acc_q) | (pop ? ex2_fflags : 5'b0);
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  // Entry storage needs no reset: head outputs are masked while empty.
  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_data;
      ff_q[wr_ptr_q]   <= ex1_fflags;
      rm_q[wr_ptr_q]   <= (ex1_decode_rm == 3'b111) ? cp0_fpu_xx_rm : ex1_decode_rm;
      wb_q[wr_ptr_q]   <= wb;
    end
  end

endmodule
